// File: rtl/mem_sched_pkg.sv
// Shared widths and per-warp state encoding for the MEM issue scheduler.
package mem_sched_pkg;
    localparam int NUM_WARPS = 8;
    localparam int WARP_ID_W = 3;
    localparam int OUTST_W   = 2;
    localparam int BACKOFF_W = 4;

    typedef enum logic {
        ST_READY   = 1'b0,
        ST_BACKOFF = 1'b1
    } warp_state_e;
endpackage

// File: rtl/mem_issue_scheduler_if.sv
// Request/grant and MEM feedback bundle between the warp front end and the scheduler.
interface mem_issue_scheduler_if;
    import mem_sched_pkg::*;

    // Handshake: warp w issues in a cycle iff req_valid_i[w] && req_ready_o[w]; ready
    // is combinational from valid, at most one bit is set, and valid need not wait on ready.
    logic [NUM_WARPS-1:0] req_valid_i;
    logic                 hold_i;
    logic                 pos_fb_valid_i;
    logic [WARP_ID_W-1:0] pos_fb_warp_i;
    logic                 neg_fb_valid_i;
    logic [WARP_ID_W-1:0] neg_fb_warp_i;
    logic [NUM_WARPS-1:0] req_ready_o;
    logic                 issue_valid_o;
    logic [WARP_ID_W-1:0] issue_warp_o;
    logic [NUM_WARPS-1:0] backoff_mask_o;
    logic                 err_underflow_o;

    modport master (
        output req_valid_i, hold_i, pos_fb_valid_i, pos_fb_warp_i, neg_fb_valid_i, neg_fb_warp_i,
        input  req_ready_o, issue_valid_o, issue_warp_o, backoff_mask_o, err_underflow_o
    );

    modport slave (
        input  req_valid_i, hold_i, pos_fb_valid_i, pos_fb_warp_i, neg_fb_valid_i, neg_fb_warp_i,
        output req_ready_o, issue_valid_o, issue_warp_o, backoff_mask_o, err_underflow_o
    );
endinterface

// File: rtl/mem_issue_scheduler_rr_pick8.sv
// Combinational round-robin pick: first set mask bit at or above the pointer, wrapping 7->0.
module rr_pick8
    import mem_sched_pkg::*;
(
    input  logic [NUM_WARPS-1:0] i_mask,
    input  logic [WARP_ID_W-1:0] i_ptr,
    output logic [NUM_WARPS-1:0] o_grant,
    output logic [WARP_ID_W-1:0] o_idx
);
    logic [WARP_ID_W-1:0] w_cand;
    logic                 w_found;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_cand  = '0;
        w_found = 1'b0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            // 3-bit add wraps naturally past warp 7
            w_cand = i_ptr + WARP_ID_W'(i);
            if (!w_found && i_mask[w_cand]) begin
                w_found         = 1'b1;
                o_idx           = w_cand;
                o_grant[w_cand] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mem_issue_scheduler.sv
// Per-warp MEM issue scheduler: outstanding-limited round-robin grant with backoff on MSHR reject.
module mem_issue_scheduler
    import mem_sched_pkg::*;
#(
    parameter int MAX_OUTST   = 2,
    parameter int BACKOFF_CYC = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    mem_issue_scheduler_if.slave   bus
);
    localparam int SUM_W = OUTST_W + 1;
    localparam logic [OUTST_W-1:0]   LP_MAX_OUTST = OUTST_W'(MAX_OUTST);
    localparam logic [BACKOFF_W-1:0] LP_BO_LOAD   = BACKOFF_W'(BACKOFF_CYC - 1);

    warp_state_e          r_state      [NUM_WARPS];
    warp_state_e          w_state_nxt  [NUM_WARPS];
    logic [BACKOFF_W-1:0] r_bo_cnt     [NUM_WARPS];
    logic [BACKOFF_W-1:0] w_bo_cnt_nxt [NUM_WARPS];
    logic [OUTST_W-1:0]   r_outst      [NUM_WARPS];
    logic [OUTST_W-1:0]   w_outst_nxt  [NUM_WARPS];
    logic [WARP_ID_W-1:0] r_ptr;
    logic [WARP_ID_W-1:0] w_ptr_nxt;
    logic                 r_err;
    logic                 w_err_nxt;
    logic                 r_first;

    logic [NUM_WARPS-1:0] w_pos_hit;
    logic [NUM_WARPS-1:0] w_neg_hit;
    logic [NUM_WARPS-1:0] w_elig;
    logic [NUM_WARPS-1:0] w_grant;
    logic [NUM_WARPS-1:0] w_uflow;
    logic [WARP_ID_W-1:0] w_idx;
    logic                 w_fire;
    logic [SUM_W-1:0]     w_sum;
    logic [SUM_W-1:0]     w_dec;

    // rst gates eligibility so no grant escapes while reset is held
    always_comb begin
        w_pos_hit = '0;
        w_neg_hit = '0;
        w_elig    = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            w_pos_hit[w] = bus.pos_fb_valid_i && (bus.pos_fb_warp_i == WARP_ID_W'(w));
            w_neg_hit[w] = bus.neg_fb_valid_i && (bus.neg_fb_warp_i == WARP_ID_W'(w));
            w_elig[w]    = rst && !bus.hold_i && bus.req_valid_i[w]
                           && (r_state[w] == ST_READY) && !w_neg_hit[w]
                           && (r_outst[w] < LP_MAX_OUTST);
        end
    end

    rr_pick8 u_pick (
        .i_mask  (w_elig),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    assign w_fire = |w_grant;

    always_comb begin
        w_ptr_nxt = r_ptr;
        w_uflow   = '0;
        w_sum     = '0;
        w_dec     = '0;
        if (w_fire) begin
            w_ptr_nxt = w_idx + WARP_ID_W'(1);
        end
        for (int w = 0; w < NUM_WARPS; w++) begin
            w_outst_nxt[w]  = r_outst[w];
            w_state_nxt[w]  = r_state[w];
            w_bo_cnt_nxt[w] = r_bo_cnt[w];

            // Grant can only happen below MAX_OUTST, so the sum never overflows OUTST_W bits
            w_sum = {1'b0, r_outst[w]} + SUM_W'(w_grant[w]);
            w_dec = SUM_W'(w_pos_hit[w]) + SUM_W'(w_neg_hit[w]);
            if (w_sum < w_dec) begin
                w_outst_nxt[w] = '0;
                w_uflow[w]     = 1'b1;
            end else begin
                w_outst_nxt[w] = OUTST_W'(w_sum - w_dec);
            end

            case (r_state[w])
                ST_READY: begin
                    if (w_neg_hit[w]) begin
                        w_state_nxt[w]  = ST_BACKOFF;
                        w_bo_cnt_nxt[w] = LP_BO_LOAD;
                    end
                end
                ST_BACKOFF: begin
                    if (w_neg_hit[w]) begin
                        w_bo_cnt_nxt[w] = LP_BO_LOAD;
                    end else if (r_bo_cnt[w] == '0) begin
                        w_state_nxt[w] = ST_READY;
                    end else begin
                        w_bo_cnt_nxt[w] = r_bo_cnt[w] - BACKOFF_W'(1);
                    end
                end
                default: begin
                    w_state_nxt[w]  = ST_READY;
                    w_bo_cnt_nxt[w] = '0;
                end
            endcase
        end
        // Stale feedback landing right after reset release saturates silently
        w_err_nxt = r_err | ((|w_uflow) & ~r_first);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                r_state[w]  <= ST_READY;
                r_bo_cnt[w] <= '0;
                r_outst[w]  <= '0;
            end
            r_ptr   <= '0;
            r_err   <= 1'b0;
            r_first <= 1'b1;
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                r_state[w]  <= w_state_nxt[w];
                r_bo_cnt[w] <= w_bo_cnt_nxt[w];
                r_outst[w]  <= w_outst_nxt[w];
            end
            r_ptr   <= w_ptr_nxt;
            r_err   <= w_err_nxt;
            r_first <= 1'b0;
        end
    end

    always_comb begin
        bus.backoff_mask_o = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            bus.backoff_mask_o[w] = (r_state[w] == ST_BACKOFF);
        end
    end

    assign bus.req_ready_o     = w_grant;
    assign bus.issue_valid_o   = w_fire;
    assign bus.issue_warp_o    = w_fire ? w_idx : '0;
    assign bus.err_underflow_o = r_err;
endmodule
